// File: rtl/z16_load_store_unit.sv
// z16_load_store_unit: byte-addressed load/store front end for the Z16 data
// memory. Word accesses go straight to the word-wide memory port; byte
// stores are performed as read-modify-write. Byte loads are sign- or
// zero-extended.
//
// Optional build macro: Z16_LSU_MISALIGN_TRAP_EN
//   defined   - word access with addr[0]=1 skips memory and responds with err=1
//   undefined - addr[0] is ignored for word accesses, err is always 0
module z16_load_store_unit #(
  parameter int ADDR_W  = 16,
  parameter int BYTE_LE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic              i_req_byte,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [15:0]       i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [15:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [15:0]       o_mem_data,
  input  logic [15:0]       i_mem_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_RMW_WR  = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  // Value of the address LSB that selects the upper lane [15:8].
  localparam logic HI_LANE_SEL = (BYTE_LE != 0) ? 1'b1 : 1'b0;

  state_t            state_q;
  logic              wr_q;
  logic              byte_q;
  logic              uns_q;
  logic              lane_q;
  logic [7:0]        wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wen_q;
  logic [15:0]       mem_data_q;
  logic              resp_valid_q;
  logic [15:0]       resp_rdata_q;
  logic              resp_err_q;

  logic              misalign_d;
  logic              hi_lane_d;
  logic [15:0]       load_val_d;
  logic [15:0]       merge_word_d;

  // Pick one byte lane out of a word and extend it to 16 bits.
  function automatic logic [15:0] extract_byte(input logic [15:0] word,
                                               input logic        hi,
                                               input logic        uns);
    logic [7:0] b;
    if (hi) begin
      b = word[15:8];
    end else begin
      b = word[7:0];
    end
    if (uns) begin
      return {8'h00, b};
    end else begin
      return {{8{b[7]}}, b};
    end
  endfunction

  // Replace one byte lane of a word with a new byte.
  function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                             input logic [7:0]  b,
                                             input logic        hi);
    if (hi) begin
      return {b, word[7:0]};
    end else begin
      return {word[15:8], b};
    end
  endfunction

  // Request decode and read-path data shaping (lane select, extend, merge).
  always_comb begin
    misalign_d   = 1'b0;
`ifdef Z16_LSU_MISALIGN_TRAP_EN
    misalign_d   = ~i_req_byte & i_req_addr[0];
`else
    misalign_d   = 1'b0;
`endif
    hi_lane_d    = (lane_q == HI_LANE_SEL);
    merge_word_d = merge_byte(i_mem_data, wdata_q, hi_lane_d);
    if (byte_q) begin
      load_val_d = extract_byte(i_mem_data, hi_lane_d, uns_q);
    end else begin
      load_val_d = i_mem_data;
    end
  end

  // Control FSM with all memory-side and response outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      byte_q       <= 1'b0;
      uns_q        <= 1'b0;
      lane_q       <= 1'b0;
      wdata_q      <= 8'h00;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wen_q    <= 1'b0;
      mem_data_q   <= 16'h0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 16'h0000;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            wr_q       <= i_req_wr;
            byte_q     <= i_req_byte;
            uns_q      <= i_req_unsigned;
            lane_q     <= i_req_addr[0];
            wdata_q    <= i_req_wdata[7:0];
            mem_addr_q <= {1'b0, i_req_addr[ADDR_W-1:1]};
            if (misalign_d) begin
              // Trapped access: answer immediately, never touch memory.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 16'h0000;
              resp_err_q   <= 1'b1;
            end else if (i_req_wr && !i_req_byte) begin
              state_q    <= S_WR;
              mem_wen_q  <= 1'b1;
              mem_data_q <= i_req_wdata;
            end else begin
              // Loads and byte stores both start with a word read.
              state_q <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          mem_wen_q    <= 1'b0;
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 16'h0000;
          resp_err_q   <= 1'b0;
        end
        S_RD_ADDR: begin
          state_q <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (wr_q) begin
            mem_data_q <= merge_word_d;
            mem_wen_q  <= 1'b1;
            state_q    <= S_RMW_WR;
          end else begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_val_d;
            resp_err_q   <= 1'b0;
            state_q      <= S_RESP;
          end
        end
        S_RMW_WR: begin
          mem_wen_q    <= 1'b0;
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 16'h0000;
          resp_err_q   <= 1'b0;
        end
        S_RESP: begin
          if (i_resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 16'h0000;
            resp_err_q   <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          mem_wen_q    <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = (state_q == S_IDLE);
  assign o_resp_valid = resp_valid_q;
  assign o_resp_rdata = resp_rdata_q;
  assign o_resp_err   = resp_err_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wen    = mem_wen_q;
  assign o_mem_data   = mem_data_q;

endmodule

// File: tb/tb_z16_load_store_unit.sv
// Self-checking bench for z16_load_store_unit with a word-wide memory model.
module tb_z16_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wr;
  logic        i_req_byte;
  logic        i_req_unsigned;
  logic [15:0] i_req_addr;
  logic [15:0] i_req_wdata;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [15:0] o_resp_rdata;
  logic        o_resp_err;
  logic [15:0] o_mem_addr;
  logic        o_mem_wen;
  logic [15:0] o_mem_data;
  logic [15:0] i_mem_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic        byt;
    logic        uns;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wens;
    int          exp_woff;
    logic [15:0] exp_maddr;
    logic [15:0] exp_mdata;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];

  always #5 i_clk = ~i_clk;

  z16_load_store_unit dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_wr       (i_req_wr),
    .i_req_byte     (i_req_byte),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_resp_valid   (o_resp_valid),
    .i_resp_ready   (i_resp_ready),
    .o_resp_rdata   (o_resp_rdata),
    .o_resp_err     (o_resp_err),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wen      (o_mem_wen),
    .o_mem_data     (o_mem_data),
    .i_mem_data     (i_mem_data)
  );

  // Data memory model: synchronous write, read data valid the cycle after the address.
  logic        mem_clear;
  logic [15:0] mem [0:65535];
  always @(posedge i_clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
    end else if (o_mem_wen) begin
      mem[o_mem_addr] <= o_mem_data;
    end
    i_mem_data <= mem[o_mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_resp();
    resp_t r;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      r = sb.pop_front();
      chk("resp_rdata", {16'h0000, o_resp_rdata}, {16'h0000, r.rdata});
      chk("resp_err", {31'd0, o_resp_err}, {31'd0, r.err});
    end
  endtask

  function automatic vec_t mk(logic wr, logic byt, logic uns, logic [15:0] addr,
                              logic [15:0] wdata, logic [15:0] exp_rdata, logic exp_err,
                              int lat, int wens, int woff, logic [15:0] maddr,
                              logic [15:0] mdata);
    vec_t v;
    v.wr = wr; v.byt = byt; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = lat;
    v.exp_wens = wens; v.exp_woff = woff; v.exp_maddr = maddr; v.exp_mdata = mdata;
    return v;
  endfunction

  // Issue one request (called right after a negedge), follow it to its response and handshake.
  task automatic run_req(input vec_t v);
    int k;
    int wens;
    int woff;
    logic [15:0] wa, wd, ra;
    chk("req_ready_idle", {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_wr = v.wr; i_req_byte = v.byt; i_req_unsigned = v.uns;
    i_req_addr = v.addr; i_req_wdata = v.wdata;
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    wens = 0; woff = -1; wa = 16'h0000; wd = 16'h0000; ra = 16'h0000;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    k = 1;
    while (1'b1) begin
      if (o_mem_wen) begin
        wens++; woff = k - 1; wa = o_mem_addr; wd = o_mem_data;
      end
      if (k == 1) ra = o_mem_addr;
      if (o_resp_valid || k >= 12) break;
      @(posedge i_clk);
      @(negedge i_clk);
      k++;
    end
    chk("resp_latency", k, v.exp_lat);
    chk("req_ready_low_in_resp", {31'd0, o_req_ready}, 32'd0);
    check_resp();
    chk("wen_cycles", wens, v.exp_wens);
    if (v.exp_wens > 0) begin
      chk("wen_offset", woff, v.exp_woff);
      chk("wen_addr", {16'h0000, wa}, {16'h0000, v.exp_maddr});
      chk("wen_data", {16'h0000, wd}, {16'h0000, v.exp_mdata});
    end
    if (v.exp_lat > 1) chk("mem_addr", {16'h0000, ra}, {16'h0000, v.exp_maddr});
    i_resp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_resp_ready = 1'b0;
    chk("resp_valid_dropped", {31'd0, o_resp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, o_req_ready}, 32'd1);
  endtask

  initial begin
    vec_t tbl[13];
    int   k;
    int   wen_seen;
    int   valid_seen;

    // Memory starts all-zero; BYTE_LE=1 (even address in bits [7:0]).
    //           wr    byt   uns   addr      wdata     rdata     err   lat wen off maddr     mdata
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 16'h1FFE, 16'h5555, 16'h0000, 1'b0, 2, 1, 0, 16'h0FFF, 16'h5555);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 16'h1FFE, 16'h0000, 16'h5555, 1'b0, 3, 0, 0, 16'h0FFF, 16'h0000);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 16'h1FFF, 16'h00AA, 16'h0000, 1'b0, 4, 1, 2, 16'h0FFF, 16'hAA55);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 16'h1FFF, 16'h0000, 16'hFFAA, 1'b0, 3, 0, 0, 16'h0FFF, 16'h0000);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 16'h1FFF, 16'h0000, 16'h00AA, 1'b0, 3, 0, 0, 16'h0FFF, 16'h0000);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 16'h1FFE, 16'h0000, 16'h0055, 1'b0, 3, 0, 0, 16'h0FFF, 16'h0000);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1280, 16'h0000, 1'b0, 4, 1, 2, 16'h0008, 16'h0080);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hFF80, 1'b0, 3, 0, 0, 16'h0008, 16'h0000);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 16'h0000, 1'b0, 3, 0, 0, 16'h0008, 16'h0000);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h1234, 16'h0000, 1'b0, 2, 1, 0, 16'h7FFF, 16'h1234);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0077, 16'h0000, 1'b0, 4, 1, 2, 16'h7FFF, 16'h7734);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h7734, 1'b0, 3, 0, 0, 16'h7FFF, 16'h0000);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0077, 1'b0, 3, 0, 0, 16'h7FFF, 16'h0000);

    i_rst = 1'b1; mem_clear = 1'b1;
    i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_byte = 1'b0; i_req_unsigned = 1'b0;
    i_req_addr = 16'h0000; i_req_wdata = 16'h0000; i_resp_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("rst_resp_rdata", {16'h0000, o_resp_rdata}, 32'd0);
    chk("rst_resp_err", {31'd0, o_resp_err}, 32'd0);
    chk("rst_mem_addr", {16'h0000, o_mem_addr}, 32'd0);
    chk("rst_mem_wen", {31'd0, o_mem_wen}, 32'd0);
    chk("rst_mem_data", {16'h0000, o_mem_data}, 32'd0);
    i_rst = 1'b0; mem_clear = 1'b0;

    for (int i = 0; i < 13; i++) run_req(tbl[i]);

    // Backpressure: hold the load response for 3 cycles while a second request is ignored.
    i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_byte = 1'b0; i_req_unsigned = 1'b0;
    i_req_addr = 16'h1FFE;
    sb.push_back('{rdata: 16'hAA55, err: 1'b0});
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    k = 1;
    while (!o_resp_valid && k < 12) begin
      @(posedge i_clk);
      @(negedge i_clk);
      k++;
    end
    chk("bp_latency", k, 3);
    i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 16'h0100; i_req_wdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_held", {31'd0, o_resp_valid}, 32'd1);
      chk("bp_rdata_held", {16'h0000, o_resp_rdata}, 32'h0000AA55);
      chk("bp_req_ready_low", {31'd0, o_req_ready}, 32'd0);
      chk("bp_no_wen", {31'd0, o_mem_wen}, 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_req_valid = 1'b0;
    check_resp();
    i_resp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_resp_ready = 1'b0;
    chk("bp_release_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, o_req_ready}, 32'd1);
    // The ignored store must not have written word 0x0080.
    run_req(mk(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b0, 3, 0, 0, 16'h0080, 16'h0000));

    // Reset while a byte store sits in RD_DATA: the RMW write must be abandoned.
    i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_byte = 1'b1; i_req_unsigned = 1'b0;
    i_req_addr = 16'h1FFF; i_req_wdata = 16'h0011;
    wen_seen = 0; valid_seen = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    if (o_mem_wen) wen_seen++;
    @(posedge i_clk);
    @(negedge i_clk);
    if (o_mem_wen) wen_seen++;
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("mid_rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, o_resp_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (o_mem_wen) wen_seen++;
      if (o_resp_valid) valid_seen++;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    chk("mid_rst_no_wen", wen_seen, 0);
    chk("mid_rst_no_resp", valid_seen, 0);
    run_req(mk(1'b0, 1'b0, 1'b0, 16'h1FFE, 16'h0000, 16'hAA55, 1'b0, 3, 0, 0, 16'h0FFF, 16'h0000));

    // Misaligned word load.
`ifdef Z16_LSU_MISALIGN_TRAP_EN
    run_req(mk(1'b0, 1'b0, 1'b0, 16'h1FFF, 16'h0000, 16'h0000, 1'b1, 1, 0, 0, 16'h0FFF, 16'h0000));
`else
    run_req(mk(1'b0, 1'b0, 1'b0, 16'h1FFF, 16'h0000, 16'hAA55, 1'b0, 3, 0, 0, 16'h0FFF, 16'h0000));
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z16_load_store_unit.md
Name: z16_load_store_unit

Overview:
- Sits between the Z16 execute stage and the Z16 data memory, directly upstream of the memory.
- Accepts one byte-addressed load/store request at a time over a valid/ready handshake and drives the memory's word-wide port (addr, wen, data in/out).
- Performs word accesses directly and byte stores as read-modify-write.
- Returns load data (byte loads sign- or zero-extended) over a valid/ready response handshake.

Parameters:
- ADDR_W, 16, width of the CPU byte address and of the memory address port.
- BYTE_LE, 1, byte lane order: 1 = byte at even address in bits [7:0]; 0 = byte at even address in bits [15:8].

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  LSU can accept; high only in IDLE.
- i_req_wr  in  1  1 = store, 0 = load.
- i_req_byte  in  1  1 = byte access, 0 = word access.
- i_req_unsigned  in  1  byte load: 1 = zero-extend, 0 = sign-extend.
- i_req_addr  in  ADDR_W  byte address.
- i_req_wdata  in  16  store data; byte store uses bits [7:0].
- o_resp_valid  out  1  response present.
- i_resp_ready  in  1  consumer takes response.
- o_resp_rdata  out  16  load result; 0 for stores.
- o_resp_err  out  1  misaligned-access error (see Optional Feature).
- o_mem_addr  out  ADDR_W  word address to data memory = {1'b0, addr[ADDR_W-1:1]}.
- o_mem_wen  out  1  memory write enable.
- o_mem_data  out  16  memory write data.
- i_mem_data  in  16  memory read data, valid the cycle after o_mem_addr is presented.

Behaviour:
- All outputs are registered except o_req_ready, which is decoded from state.
- Reset values: state IDLE, o_req_ready 1, o_resp_valid 0, o_resp_rdata 0, o_resp_err 0, o_mem_addr 0, o_mem_wen 0, o_mem_data 0.
- A request is accepted when i_req_valid & o_req_ready at a rising edge (cycle N). Request fields are latched at that edge.
- States: IDLE, WR, RD_ADDR, RD_DATA, RMW_WR, RESP.
- Word store: IDLE→WR. During N+1, o_mem_wen=1 with address/data driven; the memory writes at the end of N+1. →RESP; o_resp_valid rises in N+2.
- Word load: IDLE→RD_ADDR (N+1, wen 0)→RD_DATA (N+2, capture i_mem_data)→RESP; valid in N+3.
- Byte load: same path as word load. The selected lane is extended per i_req_unsigned.
- Byte store: RD_ADDR (N+1)→RD_DATA (N+2, merge wdata[7:0] into the addressed lane)→RMW_WR (N+3, wen 1, merged word)→RESP; valid in N+4.
- o_mem_wen is high only in WR and RMW_WR, for exactly one cycle per store.
- RESP: o_resp_valid, o_resp_rdata and o_resp_err hold stable until i_resp_ready is high at an edge, then →IDLE. o_req_ready does not rise in the same cycle as o_resp_valid; the earliest next acceptance is the cycle after the response handshake.
- Requests presented while not IDLE are ignored and not queued.
- Reset mid-operation (any state): return to IDLE at that edge with o_mem_wen cleared. Any pending RMW write is abandoned and no memory write occurs after the reset edge. Any pending response is dropped.
- Address wrap: 0xFFFF maps to word 0x7FFF. No wrap logic is required beyond truncation.

Optional Feature:
- Macro Z16_LSU_MISALIGN_TRAP_EN.
- Defined: a word access with addr[0]=1 performs no memory access (o_mem_wen stays 0). The unit goes IDLE→RESP, o_resp_valid is asserted in N+1 with o_resp_err=1 and o_resp_rdata=0.
- Undefined: addr[0] is ignored for word accesses, which proceed normally. o_resp_err is tied 0.

Test Plan:
- Reset, then word store 0x5555 to 0x1FFE → exactly one cycle of o_mem_wen=1 in N+1 with o_mem_addr 0x0FFF, o_mem_data 0x5555. Response valid in N+2, rdata 0, err 0.
- Word load from 0x1FFE after the above → o_mem_addr 0x0FFF in N+1; response in N+3 with rdata 0x5555.
- Byte store 0x00AA to 0x1FFF (BYTE_LE=1) → read N+1, write in N+3 with o_mem_data 0xAA55. A following byte load from 0x1FFF with unsigned=0 gives 0xFFAA; with unsigned=1 it gives 0x00AA.
- Hold i_resp_ready low for 3 cycles during a load response → o_resp_valid and rdata stay stable, o_req_ready stays 0, and a second request is ignored. Release → IDLE, then the next request is accepted.
- Assert i_rst in RD_DATA of a byte store → o_mem_wen never goes high, no response, state IDLE with o_req_ready 1 the next cycle. Memory word is unchanged (re-read gives 0xAA55).
- Word load from 0x1FFF: with Z16_LSU_MISALIGN_TRAP_EN, response in N+1 with err 1, rdata 0, and no memory access. Without the macro, o_mem_addr 0x0FFF, response in N+3 with rdata 0xAA55 and err 0.
